// File: rtl/mac_requant_pkg.sv
// Shared widths, FSM encoding and config payload for the MAC requantisation stage.
package mac_requant_pkg;

    localparam int unsigned ACCW   = 40;
    localparam int unsigned MULW   = 16;
    localparam int unsigned SHW    = 6;
    localparam int unsigned OUTW   = 8;
    localparam int unsigned KW     = 16;
    localparam int unsigned FDEPTH = 4;

    localparam int unsigned PRODW  = ACCW + MULW;
    localparam int unsigned RNDW   = PRODW + 1;
    localparam int unsigned ZPW    = RNDW + 1;

    localparam int OUT_MAX = int'(2 ** (OUTW - 1)) - 1;
    localparam int OUT_MIN = -int'(2 ** (OUTW - 1));

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [KW-1:0]          len_m1;
        logic signed [MULW-1:0] mult;
        logic [SHW-1:0]         shift;
        logic signed [OUTW-1:0] zp;
        logic                   relu;
    } cfg_t;

    // Index of the last beat in a window; a length of 0 behaves as 1.
    function automatic logic [KW-1:0] len_to_last(input logic [KW-1:0] len);
        return (len == '0) ? '0 : len - KW'(1);
    endfunction

endpackage

// File: rtl/mac_requant_if.sv
// Accumulator input stream and requantised output stream of mac_requant.
interface mac_requant_if;
    import mac_requant_pkg::*;

    logic            acc_valid;
    logic [ACCW-1:0] acc_in;
    logic            out_valid;
    logic            out_ready;
    logic [OUTW-1:0] out_data;

    modport master (output acc_valid, output acc_in, output out_ready,
                    input  out_valid, input  out_data);
    modport slave  (input  acc_valid, input  acc_in, input  out_ready,
                    output out_valid, output out_data);
endinterface

// File: rtl/mac_requant_sync_fifo.sv
// Reusable synchronous FIFO; push while full is accepted only with a same-cycle pop.
module mac_requant_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign o_data    = r_mem[r_rd];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_do_pop) r_rd <= r_rd + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/mac_requant.sv
// Windows the free-running MAC accumulator into dot products, requantises each
// through a fixed 4-stage pipeline and buffers the results in an output FIFO.
module mac_requant
    import mac_requant_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    mac_requant_if.slave           bus,
    input  logic                   cfg_load,
    input  logic                   cfg_flush,
    input  logic [KW-1:0]          cfg_len,
    input  logic signed [MULW-1:0] cfg_mult,
    input  logic [SHW-1:0]         cfg_shift,
    input  logic signed [OUTW-1:0] cfg_zp,
    input  logic                   cfg_relu,
    output logic                   busy,
    output logic                   sat_flag,
    output logic                   ovf_err
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_load;
    logic            w_close;
    cfg_t            r_cfg;
    logic [KW-1:0]   r_count;
    logic [ACCW-1:0] r_base;

    logic                    r_s1_v;
    logic signed [ACCW-1:0]  r_s1_delta;
    logic                    r_s2_v;
    logic signed [PRODW-1:0] r_s2_prod;
    logic                    r_s3_v;
    logic signed [RNDW-1:0]  r_s3_val;
    logic                    r_s4_v;
    logic [OUTW-1:0]         r_s4_data;

    logic signed [PRODW-1:0] w_prod;
    logic [RNDW-1:0]         w_half;
    logic signed [RNDW-1:0]  w_sum;
    logic signed [RNDW-1:0]  w_shifted;
    logic signed [RNDW-1:0]  w_relu;
    logic signed [ZPW-1:0]   w_zsum;
    logic [OUTW-1:0]         w_s4_nxt;
    logic                    w_sat;

    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Flush beats both a load and a window close in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_close     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_load && !cfg_flush) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cfg_flush) w_state_nxt = ST_IDLE;
                else if (bus.acc_valid && (r_count == r_cfg.len_m1)) w_close = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (r_state == ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg   <= '0;
            r_count <= '0;
            r_base  <= '0;
        end else if (w_load) begin
            r_cfg   <= '{len_m1: len_to_last(cfg_len), mult: cfg_mult,
                         shift: cfg_shift, zp: cfg_zp, relu: cfg_relu};
            r_count <= '0;
            r_base  <= bus.acc_in;
        end else if (r_state == ST_RUN) begin
            if (cfg_flush) begin
                r_count <= '0;
            end else if (bus.acc_valid) begin
                if (w_close) begin
                    r_count <= '0;
                    r_base  <= bus.acc_in;
                end else begin
                    r_count <= r_count + KW'(1);
                end
            end
        end
    end

    // Requant arithmetic: scale, round-half-up shift, ReLU, zero point, saturate.
    always_comb begin
        w_prod    = PRODW'(r_s1_delta) * PRODW'(r_cfg.mult);
        w_half    = (r_cfg.shift == '0) ? '0 : (RNDW'(1) << (r_cfg.shift - SHW'(1)));
        w_sum     = RNDW'(r_s2_prod) + $signed(w_half);
        w_shifted = w_sum >>> r_cfg.shift;
        w_relu    = (r_cfg.relu && r_s3_val[RNDW-1]) ? '0 : r_s3_val;
        w_zsum    = ZPW'(w_relu) + ZPW'(r_cfg.zp);
        w_sat     = 1'b0;
        w_s4_nxt  = OUTW'(w_zsum);
        if (w_zsum > ZPW'(OUT_MAX)) begin
            w_s4_nxt = OUTW'(OUT_MAX);
            w_sat    = 1'b1;
        end else if (w_zsum < ZPW'(OUT_MIN)) begin
            w_s4_nxt = OUTW'(OUT_MIN);
            w_sat    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v     <= 1'b0;
            r_s1_delta <= '0;
            r_s2_v     <= 1'b0;
            r_s2_prod  <= '0;
            r_s3_v     <= 1'b0;
            r_s3_val   <= '0;
            r_s4_v     <= 1'b0;
            r_s4_data  <= '0;
        end else begin
            r_s1_v     <= w_close;
            r_s1_delta <= bus.acc_in - r_base;
            r_s2_v     <= r_s1_v;
            r_s2_prod  <= w_prod;
            r_s3_v     <= r_s2_v;
            r_s3_val   <= w_shifted;
            r_s4_v     <= r_s3_v;
            r_s4_data  <= w_s4_nxt;
        end
    end

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_drop = r_s4_v && w_fifo_full && !bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            if (w_load) begin
                sat_flag <= 1'b0;
                ovf_err  <= 1'b0;
            end
            if (r_s3_v && w_sat) sat_flag <= 1'b1;
            if (w_drop)          ovf_err  <= 1'b1;
        end
    end

    mac_requant_sync_fifo #(
        .WIDTH (OUTW),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_s4_v),
        .i_data  (r_s4_data),
        .i_pop   (bus.out_ready),
        .o_data  (bus.out_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign bus.out_valid = !w_fifo_empty;

endmodule
